// File: rtl/ksa_pipe_adder_if.sv
// ksa_pipe_adder_if: operand/result handshake bundle for ksa_pipe_adder.
//   in_valid/in_ready    operand transfer handshake
//   in_a, in_b           operands
//   in_cin               carry-in (add) / borrow-in (sub)
//   in_sub               0 = A+B+cin, 1 = A-B-cin
//   in_tag               sideband tag, returned with the result
//   out_valid/out_ready  result transfer handshake
//   out_sum              result modulo 2^WIDTH
//   out_cout             carry out of MSB (subtract: 1 = no borrow)
//   out_ovf              two's-complement overflow
//   out_zero             out_sum == 0
//   out_tag              tag of this result
// modport slave is the adder side, modport master is the producer/consumer side.
interface ksa_pipe_adder_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
  );
endinterface

// File: rtl/ksa_pipe_adder.sv
// ksa_pipe_adder: pipelined Kogge-Stone adder/subtractor with valid/ready flow
// control, status flags and a sideband tag.
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   io_bus  ksa_pipe_adder_if.slave (operands in, result + flags out)
// Pipeline: bank 0 holds generate/propagate of the prepared operands, banks
// 1..NSTG each hold the prefix tree after LVL_PER_STAGE more levels, and the
// output bank holds sum/flags.  Latency is 1+NSTG cycles from the accepting
// edge.  Stall is global: when the output is valid but not taken, every bank
// holds, so bubbles stay in place and ordering is preserved.
module ksa_pipe_adder #(
  parameter int WIDTH         = 64,
  parameter int LVL_PER_STAGE = 2,
  parameter int TAG_W         = 4
) (
  input  logic clk,
  input  logic rst,
  ksa_pipe_adder_if.slave io_bus
);
  localparam int LOG2W = $clog2(WIDTH);
  localparam int NSTG  = (LOG2W + LVL_PER_STAGE - 1) / LVL_PER_STAGE;

  logic [WIDTH-1:0] r_g   [0:NSTG];
  logic [WIDTH-1:0] r_p   [0:NSTG];
  logic [WIDTH-1:0] r_p0  [0:NSTG];
  logic [TAG_W-1:0] r_tag [0:NSTG];
  logic [NSTG:0]    r_c;
  logic [NSTG:0]    r_v;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_out_ovf;
  logic             r_out_zero;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_stall;
  logic [WIDTH-1:0] w_beff;
  logic             w_ceff;
  logic [WIDTH-1:0] w_g [1:NSTG];
  logic [WIDTH-1:0] w_p [1:NSTG];
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  assign w_stall         = r_out_valid & ~io_bus.out_ready;
  assign io_bus.in_ready = ~w_stall;

  // Subtraction as A + ~B + ~borrow.
  assign w_beff = io_bus.in_sub ? ~io_bus.in_b : io_bus.in_b;
  assign w_ceff = io_bus.in_sub ? ~io_bus.in_cin : io_bus.in_cin;

  // Prefix level k belongs to stage k/LVL_PER_STAGE + 1.  Shifting left by the
  // level distance yields zeros below it, which makes the low bits pass through.
  always_comb begin
    logic [WIDTH-1:0] v_g;
    logic [WIDTH-1:0] v_p;
    logic [WIDTH-1:0] v_lo;
    for (int s = 1; s <= NSTG; s++) begin
      v_g  = r_g[s-1];
      v_p  = r_p[s-1];
      v_lo = '0;
      for (int k = 0; k < LOG2W; k++) begin
        if (k / LVL_PER_STAGE == s - 1) begin
          v_lo = {WIDTH{1'b1}} >> (WIDTH - (1 << k));
          v_g  = v_g | (v_p & (v_g << (1 << k)));
          v_p  = v_p & ((v_p << (1 << k)) | v_lo);
        end
      end
      w_g[s] = v_g;
      w_p[s] = v_p;
    end
  end

  // After the full tree G/P are group terms over [0..i], so the carry into bit
  // i needs only the carry-in.
  assign w_carry = {r_g[NSTG][WIDTH-2:0] | (r_p[NSTG][WIDTH-2:0] & {(WIDTH-1){r_c[NSTG]}}),
                    r_c[NSTG]};
  assign w_sum   = r_p0[NSTG] ^ w_carry;
  assign w_cout  = r_g[NSTG][WIDTH-1] | (r_p[NSTG][WIDTH-1] & r_c[NSTG]);
  assign w_ovf   = w_carry[WIDTH-1] ^ w_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= NSTG; s++) begin
        r_g[s]   <= '0;
        r_p[s]   <= '0;
        r_p0[s]  <= '0;
        r_tag[s] <= '0;
      end
      r_c         <= '0;
      r_v         <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_zero  <= 1'b0;
      r_out_tag   <= '0;
    end else if (!w_stall) begin
      r_g[0]   <= io_bus.in_a & w_beff;
      r_p[0]   <= io_bus.in_a ^ w_beff;
      r_p0[0]  <= io_bus.in_a ^ w_beff;
      r_tag[0] <= io_bus.in_tag;
      r_c[0]   <= w_ceff;
      r_v[0]   <= io_bus.in_valid;
      for (int s = 1; s <= NSTG; s++) begin
        r_g[s]   <= w_g[s];
        r_p[s]   <= w_p[s];
        r_p0[s]  <= r_p0[s-1];
        r_tag[s] <= r_tag[s-1];
        r_c[s]   <= r_c[s-1];
        r_v[s]   <= r_v[s-1];
      end
      r_out_valid <= r_v[NSTG];
      r_out_sum   <= w_sum;
      r_out_cout  <= w_cout;
      r_out_ovf   <= w_ovf;
      r_out_zero  <= (w_sum == '0);
      r_out_tag   <= r_tag[NSTG];
    end
  end

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_sum   = r_out_sum;
  assign io_bus.out_cout  = r_out_cout;
  assign io_bus.out_ovf   = r_out_ovf;
  assign io_bus.out_zero  = r_out_zero;
  assign io_bus.out_tag   = r_out_tag;
endmodule

// File: tb/tb_ksa_pipe_adder.sv
// tb_ksa_pipe_adder: self-checking bench for ksa_pipe_adder.  Default 64-bit
// instance for directed/back-to-back/reset scenarios; 16-bit/1-level and
// 32-bit/5-level instances for randomized runs against a behavioural model.
module tb_ksa_pipe_adder;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;

  ksa_pipe_adder_if #(.WIDTH(64), .TAG_W(4)) b64();
  ksa_pipe_adder_if #(.WIDTH(16), .TAG_W(4)) b16();
  ksa_pipe_adder_if #(.WIDTH(32), .TAG_W(4)) b32();

  ksa_pipe_adder #(.WIDTH(64), .LVL_PER_STAGE(2), .TAG_W(4)) dut64 (.clk(clk), .rst(rst), .io_bus(b64));
  ksa_pipe_adder #(.WIDTH(16), .LVL_PER_STAGE(1), .TAG_W(4)) dut16 (.clk(clk), .rst(rst), .io_bus(b16));
  ksa_pipe_adder #(.WIDTH(32), .LVL_PER_STAGE(5), .TAG_W(4)) dut32 (.clk(clk), .rst(rst), .io_bus(b32));

  // Plain wide-integer reference, independent of any prefix structure.
  function automatic exp_t model(logic [63:0] a, logic [63:0] b, logic cin, logic sub,
                                 logic [3:0] tag, int w);
    logic [64:0] mask, aa, bb, full, low;
    logic        ceff;
    exp_t        e;
    mask   = (65'd1 << w) - 65'd1;
    aa     = {1'b0, a} & mask;
    bb     = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    ceff   = sub ? ~cin : cin;
    full   = aa + bb + 65'(ceff);
    low    = (aa & (mask >> 1)) + (bb & (mask >> 1)) + 65'(ceff);
    e.sum  = full[63:0] & mask[63:0];
    e.cout = full[w];
    e.ovf  = low[w-1] ^ e.cout;
    e.zero = (e.sum == 64'd0);
    e.tag  = tag;
    return e;
  endfunction

  // Single op on the 64-bit instance with the output always ready; lat counts
  // rising edges after the accepting edge until out_valid.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic sub, input logic [3:0] tag, output exp_t got, output int lat);
    @(negedge clk);
    b64.in_valid = 1'b1; b64.in_a = a; b64.in_b = b; b64.in_cin = cin;
    b64.in_sub = sub; b64.in_tag = tag; b64.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b64.in_valid = 1'b0;
    lat = 0;
    while (b64.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = '{b64.out_sum, b64.out_cout, b64.out_ovf, b64.out_zero, b64.out_tag};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b64.out_ready = 1'b0;
    #12;
    total++; if (b64.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", b64.out_valid); end
    total++; if (b64.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", b64.in_ready); end
    total++; if (b64.out_sum !== 64'd0) begin bad++; $display("FAIL rst_out_sum: got %h want 0", b64.out_sum); end
    total++; if ({b64.out_cout, b64.out_ovf, b64.out_zero} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {b64.out_cout, b64.out_ovf, b64.out_zero}); end
    total++; if (b64.out_tag !== 4'd0) begin bad++; $display("FAIL rst_out_tag: got %h want 0", b64.out_tag); end
    total++; if ({b16.out_valid, b32.out_valid} !== 2'b00) begin bad++; $display("FAIL rst_small_valid: got %b want 00", {b16.out_valid, b32.out_valid}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (b64.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", b64.in_ready); end
  endtask

  task automatic test_add_wrap();
    exp_t g; int lat;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'h1, g, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL wrap_latency: got %0d want 4", lat); end
    total++; if (g.sum !== 64'd0) begin bad++; $display("FAIL wrap_sum: got %h want 0", g.sum); end
    total++; if ({g.cout, g.ovf, g.zero} !== 3'b101) begin bad++; $display("FAIL wrap_flags: got %b want 101", {g.cout, g.ovf, g.zero}); end
    total++; if (g.tag !== 4'h1) begin bad++; $display("FAIL wrap_tag: got %h want 1", g.tag); end
  endtask

  task automatic test_sub();
    exp_t g; int lat;
    run_op(64'd5, 64'd7, 1'b0, 1'b1, 4'h2, g, lat);
    total++; if (g.sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL sub_5_7_sum: got %h want fffffffffffffffe", g.sum); end
    total++; if ({g.cout, g.ovf, g.zero} !== 3'b000) begin bad++; $display("FAIL sub_5_7_flags: got %b want 000", {g.cout, g.ovf, g.zero}); end
    run_op(64'd7, 64'd5, 1'b1, 1'b1, 4'h3, g, lat);
    total++; if (g.sum !== 64'd1) begin bad++; $display("FAIL sub_7_5_sum: got %h want 1", g.sum); end
    total++; if (g.cout !== 1'b1) begin bad++; $display("FAIL sub_7_5_cout: got %b want 1", g.cout); end
    total++; if (g.tag !== 4'h3) begin bad++; $display("FAIL sub_7_5_tag: got %h want 3", g.tag); end
  endtask

  task automatic test_ovf();
    exp_t g; int lat;
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'h4, g, lat);
    total++; if (g.sum !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf_sum: got %h want 8000000000000000", g.sum); end
    total++; if ({g.cout, g.ovf, g.zero} !== 3'b010) begin bad++; $display("FAIL ovf_flags: got %b want 010", {g.cout, g.ovf, g.zero}); end
  endtask

  task automatic test_back_to_back();
    exp_t q[$]; exp_t e;
    int sent = 0, rcv = 0, cyc = 0, extra = 0;
    logic [63:0] a, b, held;
    logic [3:0] held_tag;
    logic cin, sub, was_stall = 1'b0;
    while (rcv < 16 && cyc < 300) begin
      @(negedge clk);
      b64.out_ready = (cyc % 3 == 0);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cin = 1'($urandom_range(0, 1)); sub = 1'(sent % 2);
      b64.in_valid = (sent < 16); b64.in_a = a; b64.in_b = b;
      b64.in_cin = cin; b64.in_sub = sub; b64.in_tag = 4'(sent);
      #1;
      if (was_stall) begin
        total++;
        if (b64.out_valid !== 1'b1 || b64.out_sum !== held || b64.out_tag !== held_tag) begin
          bad++; $display("FAIL b2b_stall_hold: got v=%b sum=%h tag=%h want v=1 sum=%h tag=%h",
                          b64.out_valid, b64.out_sum, b64.out_tag, held, held_tag);
        end
      end
      total++;
      if (b64.in_ready !== !(b64.out_valid && !b64.out_ready)) begin
        bad++; $display("FAIL b2b_in_ready: got %b with out_valid=%b out_ready=%b", b64.in_ready, b64.out_valid, b64.out_ready);
      end
      was_stall = b64.out_valid && !b64.out_ready;
      held = b64.out_sum; held_tag = b64.out_tag;
      if (b64.out_valid && b64.out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected: got tag %h want nothing", b64.out_tag);
        end else begin
          e = q.pop_front();
          if (b64.out_sum !== e.sum || b64.out_tag !== e.tag ||
              {b64.out_cout, b64.out_ovf, b64.out_zero} !== {e.cout, e.ovf, e.zero}) begin
            bad++; $display("FAIL b2b_result: got sum=%h tag=%h f=%b want sum=%h tag=%h f=%b", b64.out_sum, b64.out_tag,
                            {b64.out_cout, b64.out_ovf, b64.out_zero}, e.sum, e.tag, {e.cout, e.ovf, e.zero});
          end
        end
        rcv++;
      end
      if (b64.in_valid && b64.in_ready) begin
        q.push_back(model(a, b, cin, sub, 4'(sent), 64));
        sent++;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    b64.in_valid = 1'b0; b64.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b64.out_valid === 1'b1) extra++;
    end
    total++; if (rcv !== 16) begin bad++; $display("FAIL b2b_count: got %0d want 16", rcv); end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL b2b_leftover: got %0d want 0", q.size()); end
    total++; if (extra !== 0) begin bad++; $display("FAIL b2b_duplicate: got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    exp_t g; int lat, n = 0, seen = 0;
    b64.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b64.in_valid = 1'b1; b64.in_a = 64'(100 + i); b64.in_b = 64'd1;
      b64.in_cin = 1'b0; b64.in_sub = 1'b0; b64.in_tag = 4'(4'hA + i);
    end
    @(negedge clk);
    b64.in_valid = 1'b0;
    while (b64.out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (b64.out_valid !== 1'b1) begin bad++; $display("FAIL rmid_inflight: got %b want 1", b64.out_valid); end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (b64.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_async_clear: got %b want 0", b64.out_valid); end
    total++; if (b64.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready: got %b want 1", b64.in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b64.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b64.out_valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rmid_ghost: got %0d want 0", seen); end
    run_op(64'd40, 64'd2, 1'b1, 1'b0, 4'hD, g, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL rmid_latency: got %0d want 4", lat); end
    total++; if (g.sum !== 64'd43 || g.tag !== 4'hD) begin bad++; $display("FAIL rmid_result: got sum=%h tag=%h want sum=2b tag=d", g.sum, g.tag); end
  endtask

  task automatic test_random();
    fork
      begin : r16
        exp_t q[$]; exp_t e;
        int sent = 0, rcv = 0, cyc = 0, lat = 0;
        logic [63:0] a, b; logic cin, sub;
        @(negedge clk);
        a = 64'($urandom); b = 64'($urandom); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        b16.in_valid = 1'b1; b16.in_a = a[15:0]; b16.in_b = b[15:0]; b16.in_cin = cin;
        b16.in_sub = sub; b16.in_tag = 4'h9; b16.out_ready = 1'b1;
        e = model(a, b, cin, sub, 4'h9, 16);
        @(posedge clk); @(negedge clk);
        b16.in_valid = 1'b0;
        while (b16.out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        total++; if (lat !== 5) begin bad++; $display("FAIL w16_latency: got %0d want 5", lat); end
        total++; if (b16.out_sum !== e.sum[15:0] || b16.out_tag !== 4'h9) begin bad++; $display("FAIL w16_first: got %h want %h", b16.out_sum, e.sum[15:0]); end
        while (rcv < 10000 && cyc < 40000) begin
          @(negedge clk);
          a = 64'($urandom); b = 64'($urandom); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
          b16.out_ready = ($urandom_range(0, 3) != 0);
          b16.in_valid = (sent < 10000) && ($urandom_range(0, 7) != 0);
          b16.in_a = a[15:0]; b16.in_b = b[15:0]; b16.in_cin = cin; b16.in_sub = sub; b16.in_tag = 4'(sent);
          #1;
          if (b16.out_valid && b16.out_ready) begin
            total++;
            if (q.size() == 0) begin bad++; $display("FAIL w16_unexpected: got tag %h want nothing", b16.out_tag); end
            else begin
              e = q.pop_front();
              if (b16.out_sum !== e.sum[15:0] || b16.out_tag !== e.tag ||
                  {b16.out_cout, b16.out_ovf, b16.out_zero} !== {e.cout, e.ovf, e.zero}) begin
                bad++; $display("FAIL w16_result: got sum=%h tag=%h f=%b want sum=%h tag=%h f=%b", b16.out_sum, b16.out_tag,
                                {b16.out_cout, b16.out_ovf, b16.out_zero}, e.sum[15:0], e.tag, {e.cout, e.ovf, e.zero});
              end
            end
            rcv++;
          end
          if (b16.in_valid && b16.in_ready) begin q.push_back(model(a, b, cin, sub, 4'(sent), 16)); sent++; end
          @(posedge clk);
          cyc++;
        end
        @(negedge clk); b16.in_valid = 1'b0;
        total++; if (rcv !== 10000 || q.size() !== 0) begin bad++; $display("FAIL w16_count: got rcv=%0d left=%0d want 10000/0", rcv, q.size()); end
      end
      begin : r32
        exp_t q[$]; exp_t e;
        int sent = 0, rcv = 0, cyc = 0, lat = 0;
        logic [63:0] a, b; logic cin, sub;
        @(negedge clk);
        a = 64'($urandom); b = 64'($urandom); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        b32.in_valid = 1'b1; b32.in_a = a[31:0]; b32.in_b = b[31:0]; b32.in_cin = cin;
        b32.in_sub = sub; b32.in_tag = 4'h6; b32.out_ready = 1'b1;
        e = model(a, b, cin, sub, 4'h6, 32);
        @(posedge clk); @(negedge clk);
        b32.in_valid = 1'b0;
        while (b32.out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        total++; if (lat !== 2) begin bad++; $display("FAIL w32_latency: got %0d want 2", lat); end
        total++; if (b32.out_sum !== e.sum[31:0] || b32.out_tag !== 4'h6) begin bad++; $display("FAIL w32_first: got %h want %h", b32.out_sum, e.sum[31:0]); end
        while (rcv < 10000 && cyc < 40000) begin
          @(negedge clk);
          a = 64'($urandom); b = 64'($urandom); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
          b32.out_ready = ($urandom_range(0, 3) != 0);
          b32.in_valid = (sent < 10000) && ($urandom_range(0, 7) != 0);
          b32.in_a = a[31:0]; b32.in_b = b[31:0]; b32.in_cin = cin; b32.in_sub = sub; b32.in_tag = 4'(sent);
          #1;
          if (b32.out_valid && b32.out_ready) begin
            total++;
            if (q.size() == 0) begin bad++; $display("FAIL w32_unexpected: got tag %h want nothing", b32.out_tag); end
            else begin
              e = q.pop_front();
              if (b32.out_sum !== e.sum[31:0] || b32.out_tag !== e.tag ||
                  {b32.out_cout, b32.out_ovf, b32.out_zero} !== {e.cout, e.ovf, e.zero}) begin
                bad++; $display("FAIL w32_result: got sum=%h tag=%h f=%b want sum=%h tag=%h f=%b", b32.out_sum, b32.out_tag,
                                {b32.out_cout, b32.out_ovf, b32.out_zero}, e.sum[31:0], e.tag, {e.cout, e.ovf, e.zero});
              end
            end
            rcv++;
          end
          if (b32.in_valid && b32.in_ready) begin q.push_back(model(a, b, cin, sub, 4'(sent), 32)); sent++; end
          @(posedge clk);
          cyc++;
        end
        @(negedge clk); b32.in_valid = 1'b0;
        total++; if (rcv !== 10000 || q.size() !== 0) begin bad++; $display("FAIL w32_count: got rcv=%0d left=%0d want 10000/0", rcv, q.size()); end
      end
    join
  endtask

  initial begin
    rst = 1'b1;
    b64.in_valid = 1'b0; b64.in_a = '0; b64.in_b = '0; b64.in_cin = 1'b0; b64.in_sub = 1'b0; b64.in_tag = '0; b64.out_ready = 1'b0;
    b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.in_cin = 1'b0; b16.in_sub = 1'b0; b16.in_tag = '0; b16.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.in_a = '0; b32.in_b = '0; b32.in_cin = 1'b0; b32.in_sub = 1'b0; b32.in_tag = '0; b32.out_ready = 1'b1;
    test_reset();
    test_add_wrap();
    test_sub();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
